pc_exc_unit: RTL and testbench
==============================

Name: pc_exc_unit

Overview:
- Receiving end of the next-PC selection path: holds the architectural PC register, which loads the selected next-PC value, and the EPC register that feeds the EPC input of that selection path.
- Runs the exception-entry sequence:
  - saves PC-4 into EPC;
  - reads a one-byte handler address from a fixed memory vector;
  - loads that address, zero-extended, into PC.
- Sits between the next-PC mux, the control unit and the memory port in the multicycle datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- MEM_LAT, 1, memory read latency in cycles (legal 1..7).
- VEC_OPCODE, 32'd253, vector address for invalid opcode.
- VEC_OVF, 32'd254, vector address for arithmetic overflow.
- VEC_DIV0, 32'd255, vector address for divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_next  in  32  selected next-PC value from the PC mux.
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  conditional PC load (branch).
- branch_taken  in  1  branch condition from ALU compare.
- exc_req  in  2  exception request: 00 none, 01 opcode, 10 overflow, 11 div-by-zero.
- mem_rbyte  in  8  byte returned by the memory read.
- pc_out  out  32  current PC.
- epc_out  out  32  current EPC; drives the EPC input of the PC mux.
- mem_addr  out  32  vector address for the exception read.
- mem_rd  out  1  one-cycle memory read strobe.
- exc_busy  out  1  exception sequence in progress; control unit stalls.
- exc_done  out  1  one-cycle pulse when the handler PC has been loaded.

Behaviour:
- Reset (synchronous, active-high, dominates all else):
  - pc_out=RESET_PC; epc_out=0; mem_addr=0; mem_rd=0.
  - exc_busy=0; exc_done=0; state=IDLE; counter=0.
  - Reset mid-sequence aborts the sequence with no PC/EPC update.
- States: IDLE, WAIT, DONE.
- IDLE, exc_req==00:
  - PC loads pc_next at the edge if pc_write=1, or if pc_write_cond=1 and branch_taken=1; otherwise PC holds.
  - EPC holds.
- IDLE, exc_req!=00 at edge t:
  - EPC <= pc_out - 32'd4, modulo 2^32 (PC=0 gives EPC=32'hFFFF_FFFC).
  - mem_addr <= vector selected by exc_req; mem_rd <= 1 for exactly one cycle.
  - counter <= 0; state <= WAIT.
  - PC is not loaded from pc_next; the exception wins over simultaneous pc_write/pc_write_cond.
- WAIT:
  - exc_busy=1; mem_rd=0 after its first cycle; counter increments each cycle.
  - When counter==MEM_LAT-1, mem_rbyte is valid; at that edge PC <= {24'b0, mem_rbyte} and state <= DONE.
  - pc_write, pc_write_cond and exc_req are ignored; a new exception is dropped, not queued.
- DONE:
  - exc_busy=1; exc_done=1 for this single cycle.
  - Next edge: state <= IDLE.
  - Control inputs are ignored.
- Latency with MEM_LAT=1:
  - exc_req sampled at edge t.
  - PC holds the handler address after edge t+1.
  - exc_done is high during cycle t+2.
  - Back in IDLE after edge t+2.
  - In general, the handler PC is loaded MEM_LAT edges after the request edge.
- mem_addr holds the last vector address until the next exception.
- exc_busy and exc_done are decoded from registered state only; there is no combinational path from inputs.
- EPC is written only on exception entry; a return-from-exception is done by the control unit selecting the EPC mux input with pc_write=1.

Optional Feature:
- Macro: PC_EXC_CAUSE_EN.
- When defined:
  - Extra output port exc_cause [1:0] captures exc_req at exception entry.
  - exc_cause resets to 00 and holds until the next entry.
  - Extra input cause_clr clears exc_cause to 00 in IDLE; set (entry) wins over a simultaneous clear.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset sequence: pc_out=0, epc_out=0, exc_busy=0.
- Load then branch:
  - pc_next=0x40, pc_write=1 for 1 cycle → pc_out=0x40.
  - pc_next=0x80, pc_write_cond=1, branch_taken=0 → pc_out stays 0x40.
  - Same with branch_taken=1 → pc_out=0x80.
- Overflow exception:
  - Setup: pc_out=0x100, exc_req=10, mem_rbyte=0x2C, MEM_LAT=1.
  - epc_out=0xFC and mem_addr=254 with a 1-cycle mem_rd.
  - pc_out=0x2C one edge later; exc_done pulses once; exc_busy is high for 2 cycles.
- Exception vs. write, plus wrap-around:
  - Setup: pc_out=0, exc_req=01 together with pc_write=1 and pc_next=0x999.
  - epc_out=0xFFFF_FFFC and mem_addr=253.
  - pc_out never becomes 0x999.
- Busy drop, reset abort, latency:
  - During WAIT, assert exc_req=11 and pc_write=1 → both ignored; only one exc_done pulse.
  - Assert reset during WAIT → pc_out=RESET_PC, exc_busy=0, and no exc_done follows.
  - With MEM_LAT=3, the PC load occurs exactly 3 edges after the request.
- PC_EXC_CAUSE_EN build:
  - Div-by-zero exception → exc_cause=11 and PC loaded from mem_addr=255.
  - cause_clr in IDLE → exc_cause=00.

Source files
------------

// File: rtl/pc_exc_unit.sv
// PC/EPC registers plus exception-entry sequencer (EPC<=PC-4, fetch handler byte from vector, load PC).
// Handler PC is loaded MEM_LAT edges after the request; exc_done follows one cycle later; no input backpressure, requests during busy are dropped.
// Optional build macro PC_EXC_CAUSE_EN adds exc_cause capture with cause_clr.
module pc_exc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_taken,
    input  logic [1:0]  exc_req,
    input  logic [7:0]  mem_rbyte,
`ifdef PC_EXC_CAUSE_EN
    input  logic        cause_clr,
    output logic [1:0]  exc_cause,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        exc_busy,
    output logic        exc_done
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        exc_start;
    logic        rd_last;
    logic        pc_load;
    logic [31:0] vec_addr;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        exc_start = 1'b0;
        rd_last   = 1'b0;
        pc_load   = 1'b0;
        case (state)
            IDLE: begin
                if (exc_req != 2'b00) begin
                    exc_start = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    pc_load = pc_write | (pc_write_cond & branch_taken);
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    rd_last   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (exc_req)
            2'b01:   vec_addr = VEC_OPCODE;
            2'b10:   vec_addr = VEC_OVF;
            default: vec_addr = VEC_DIV0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out   <= RESET_PC;
            epc_out  <= 32'd0;
            mem_addr <= 32'd0;
            mem_rd   <= 1'b0;
            cnt      <= 3'd0;
        end else begin
            mem_rd <= exc_start;
            if (exc_start) begin
                // Wraps naturally: PC=0 yields EPC=FFFF_FFFC.
                epc_out  <= pc_out - 32'd4;
                mem_addr <= vec_addr;
                cnt      <= 3'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 3'd1;
            end
            if (rd_last)
                pc_out <= {24'b0, mem_rbyte};
            else if (pc_load)
                pc_out <= pc_next;
        end
    end

    assign exc_busy = (state != IDLE);
    assign exc_done = (state == DONE);

`ifdef PC_EXC_CAUSE_EN
    // Entry has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)
            exc_cause <= 2'b00;
        else if (exc_start)
            exc_cause <= exc_req;
        else if (cause_clr && state == IDLE)
            exc_cause <= 2'b00;
    end
`endif

endmodule

// File: tb/tb_pc_exc_unit.sv
// Scoreboard bench for pc_exc_unit: MEM_LAT=1 instance is scoreboarded, a MEM_LAT=3 twin checks latency.
module tb_pc_exc_unit;

    typedef struct {
        logic [31:0] epc;
        logic [31:0] addr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond, branch_taken;
    logic [1:0]  exc_req;
    logic [7:0]  mem_rbyte;
    logic        cause_clr;

    logic [31:0] pc1, epc1, addr1, pc3, epc3, addr3;
    logic        rd1, busy1, done1, rd3, busy3, done3;
    logic [1:0]  cause1, cause3;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pc_exc_unit #(.MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
        .exc_req(exc_req), .mem_rbyte(mem_rbyte),
`ifdef PC_EXC_CAUSE_EN
        .cause_clr(cause_clr), .exc_cause(cause1),
`endif
        .pc_out(pc1), .epc_out(epc1), .mem_addr(addr1), .mem_rd(rd1),
        .exc_busy(busy1), .exc_done(done1)
    );

    pc_exc_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
        .exc_req(exc_req), .mem_rbyte(mem_rbyte),
`ifdef PC_EXC_CAUSE_EN
        .cause_clr(cause_clr), .exc_cause(cause3),
`endif
        .pc_out(pc3), .epc_out(epc3), .mem_addr(addr3), .mem_rd(rd3),
        .exc_busy(busy3), .exc_done(done3)
    );

`ifndef PC_EXC_CAUSE_EN
    assign cause1 = 2'b00;
    assign cause3 = 2'b00;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each exc_done pulse retires one expected exception entry.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done1}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc",   pc1,   mon_e.pc);
                check("sb_epc",  epc1,  mon_e.epc);
                check("sb_addr", addr1, mon_e.addr);
                check("sb_busy", {31'b0, busy1}, 32'd1);
            end
        end
    end

    initial begin
        reset = 1'b1; pc_next = '0; pc_write = 0; pc_write_cond = 0;
        branch_taken = 0; exc_req = 2'b00; mem_rbyte = 8'h00; cause_clr = 0;
        step(); step();
        check("rst_pc",   pc1,   32'h0);
        check("rst_epc",  epc1,  32'h0);
        check("rst_addr", addr1, 32'h0);
        check("rst_rd",   {31'b0, rd1},   32'd0);
        check("rst_busy", {31'b0, busy1}, 32'd0);
        check("rst_done", {31'b0, done1}, 32'd0);
        reset = 1'b0;

        // Unconditional load then conditional branch not-taken / taken
        pc_next = 32'h40; pc_write = 1; step(); pc_write = 0;
        check("load_pc", pc1, 32'h40);
        pc_next = 32'h80; pc_write_cond = 1; branch_taken = 0; step();
        check("br_not_taken", pc1, 32'h40);
        branch_taken = 1; step();
        check("br_taken", pc1, 32'h80);
        pc_write_cond = 0; branch_taken = 0;

        // Overflow exception; MEM_LAT=3 twin checks load latency
        pc_next = 32'h100; pc_write = 1; step(); pc_write = 0;
        exc_req = 2'b10; mem_rbyte = 8'h2C;
        sb.push_back('{epc: 32'hFC, addr: 32'd254, pc: 32'h2C});
        step(); exc_req = 2'b00;
        check("ovf_epc",   epc1,  32'hFC);
        check("ovf_addr",  addr1, 32'd254);
        check("ovf_rd",    {31'b0, rd1},   32'd1);
        check("ovf_busy0", {31'b0, busy1}, 32'd1);
        check("ovf_pc_t",  pc1,   32'h100);
        step();
        check("ovf_rd_off", {31'b0, rd1},   32'd0);
        check("ovf_pc",     pc1,   32'h2C);
        check("ovf_busy1",  {31'b0, busy1}, 32'd1);
        check("ovf_done",   {31'b0, done1}, 32'd1);
        check("lat3_pc_t1", pc3,   32'h100);
        step();
        check("ovf_idle",   {31'b0, busy1}, 32'd0);
        check("ovf_done0",  {31'b0, done1}, 32'd0);
        check("lat3_pc_t2", pc3,   32'h100);
        step();
        check("lat3_pc_t3", pc3,   32'h2C);
        check("lat3_done",  {31'b0, done3}, 32'd1);
        step();
        check("lat3_idle",  {31'b0, busy3}, 32'd0);
        check("ovf_one_done", done_cnt, 32'd1);

        // Exception beats simultaneous write; EPC wraps below zero
        pc_next = 32'h0; pc_write = 1; step();
        exc_req = 2'b01; pc_next = 32'h999; mem_rbyte = 8'h10;
        sb.push_back('{epc: 32'hFFFF_FFFC, addr: 32'd253, pc: 32'h10});
        step(); exc_req = 2'b00; pc_write = 0;
        check("wrap_epc",  epc1,  32'hFFFF_FFFC);
        check("wrap_addr", addr1, 32'd253);
        check("wrap_pc_t", pc1,   32'h0);
        step();
        check("wrap_pc",   pc1,   32'h10);
        repeat (3) step();
        check("wrap_pc3",  pc3,   32'h10);
        check("wrap_done_cnt", done_cnt, 32'd2);

        // New request and writes during WAIT/DONE are dropped
        exc_req = 2'b10; mem_rbyte = 8'h55;
        sb.push_back('{epc: 32'h0C, addr: 32'd254, pc: 32'h55});
        step();
        exc_req = 2'b11; pc_write = 1; pc_next = 32'h777;
        step();
        check("drop_pc_wait", pc1, 32'h55);
        step();
        check("drop_pc_done", pc1,   32'h55);
        check("drop_addr",    addr1, 32'd254);
        check("drop_epc",     epc1,  32'h0C);
        exc_req = 2'b00; pc_write = 0;
        repeat (3) step();
        check("drop_one_done", done_cnt, 32'd3);
        check("drop_pc3",      pc3,      32'h55);

        // Reset during WAIT aborts with no handler load
        exc_req = 2'b11; mem_rbyte = 8'h99;
        step();
        exc_req = 2'b00; reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_pc",   pc1,  32'h0);
        check("abort_epc",  epc1, 32'h0);
        check("abort_busy", {31'b0, busy1}, 32'd0);
        repeat (4) step();
        check("abort_no_done", done_cnt, 32'd3);
        check("abort_pc_after", pc1, 32'h0);
        check("abort_pc3", pc3, 32'h0);

`ifdef PC_EXC_CAUSE_EN
        exc_req = 2'b11; mem_rbyte = 8'h42;
        sb.push_back('{epc: 32'hFFFF_FFFC, addr: 32'd255, pc: 32'h42});
        step(); exc_req = 2'b00;
        check("cause_div0", {30'b0, cause1}, 32'd3);
        repeat (4) step();
        check("cause_hold", {30'b0, cause1}, 32'd3);
        cause_clr = 1; step(); cause_clr = 0;
        check("cause_clr", {30'b0, cause1}, 32'd0);
        cause_clr = 1; exc_req = 2'b01;
        sb.push_back('{epc: 32'h3E, addr: 32'd253, pc: 32'h42});
        step(); cause_clr = 0; exc_req = 2'b00;
        check("cause_set_wins", {30'b0, cause1}, 32'd1);
        repeat (4) step();
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
